// File: rtl/usb_send_pkt_pre_arb.sv
// Round-robin front-end for the shared USB send-packet engine.
// Inserts a PRE packet plus hub-setup gap ahead of every low-speed non-SOF PID.
module usb_send_pkt_pre_arb #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned PRE_GAP = 4,
  parameter logic [3:0]  PRE_PID = 4'hC,
  parameter logic [3:0]  SOF_PID = 4'h5,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*NUM_CH-1:0] req_pid,
  input  logic [NUM_CH-1:0]   req_wen,
  input  logic [NUM_CH-1:0]   req_ls,
  output logic [NUM_CH-1:0]   req_ready,
  output logic [3:0]          pkt_pid,
  output logic                pkt_wen,
  input  logic                pkt_rdy,
  output logic [CH_W-1:0]     grant_ch,
  output logic                busy
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_WAIT_PRE, S_STB_PRE, S_DRP_PRE, S_DONE_PRE,
    S_GAP, S_WAIT_PKT, S_STB_PKT, S_DRP_PKT, S_DONE_PKT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NUM_CH-1:0] r_req_ready;
  logic [3:0]        r_pid [NUM_CH];
  logic [NUM_CH-1:0] r_ls;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_grant;
  logic              r_busy;
  logic [3:0]        r_pkt_pid;
  logic              r_pkt_wen;
  logic [7:0]        r_gap_cnt;

  logic [NUM_CH-1:0] w_pending;
  logic              w_found;
  logic [CH_W-1:0]   w_win;
  logic [CH_W-1:0]   w_rr_nxt;
  logic              w_pre_need;
  logic              w_grant;
  logic              w_release;
  logic              w_done;
  logic              w_gap_load;

  // A channel is pending exactly while its one-deep latch is occupied
  assign w_pending = ~r_req_ready;

  // First pending channel at or after rr_ptr, modulo NUM_CH
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!w_found && w_pending[i] && ((32'(r_rr_ptr) + k) % NUM_CH == i)) begin
          w_found = 1'b1;
          w_win   = CH_W'(i);
        end
      end
    end
  end

  assign w_rr_nxt   = (32'(w_win) == NUM_CH - 32'd1) ? '0 : CH_W'(32'(w_win) + 32'd1);
  assign w_pre_need = r_ls[w_win] && (r_pid[w_win] != SOF_PID);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  // The pkt_rdy seen in DONE_PRE doubles as the ready check when no gap follows,
  // and the WAIT_PKT cycle counts as the last gap cycle otherwise.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    w_done      = 1'b0;
    w_gap_load  = 1'b0;
    unique case (r_state)
      S_INIT:     w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = w_pre_need ? S_WAIT_PRE : S_WAIT_PKT;
        end
      end
      S_WAIT_PRE: if (pkt_rdy) w_state_nxt = S_STB_PRE;
      S_STB_PRE:  w_state_nxt = S_DRP_PRE;
      S_DRP_PRE:  w_state_nxt = S_DONE_PRE;
      S_DONE_PRE: begin
        if (pkt_rdy) begin
          if (PRE_GAP == 0)      w_state_nxt = S_STB_PKT;
          else if (PRE_GAP == 1) w_state_nxt = S_WAIT_PKT;
          else begin
            w_state_nxt = S_GAP;
            w_gap_load  = 1'b1;
          end
        end
      end
      S_GAP:      if (r_gap_cnt == 8'd1) w_state_nxt = S_WAIT_PKT;
      S_WAIT_PKT: if (pkt_rdy) w_state_nxt = S_STB_PKT;
      S_STB_PKT:  w_state_nxt = S_DRP_PKT;
      S_DRP_PKT: begin
        w_state_nxt = S_DONE_PKT;
        w_release   = 1'b1;
      end
      S_DONE_PKT: begin
        if (pkt_rdy) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default:    w_state_nxt = S_INIT;
    endcase
  end

  // Registered outputs are decoded from the next state so strobes align with STB_*
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_wen <= 1'b0;
      r_pkt_pid <= 4'h0;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_busy    <= 1'b0;
      r_gap_cnt <= 8'd0;
    end else begin
      r_pkt_wen <= (w_state_nxt == S_STB_PRE) || (w_state_nxt == S_STB_PKT);
      if (w_state_nxt == S_STB_PRE)      r_pkt_pid <= PRE_PID;
      else if (w_state_nxt == S_STB_PKT) r_pkt_pid <= r_pid[r_grant];
      if (w_grant) begin
        r_grant  <= w_win;
        r_rr_ptr <= w_rr_nxt;
        r_busy   <= 1'b1;
      end else if (w_done) begin
        r_busy   <= 1'b0;
      end
      if (w_gap_load)           r_gap_cnt <= 8'(PRE_GAP - 32'd1);
      else if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - 8'd1;
    end
  end

  // Per-channel one-deep request latch; freed once the real PID has been strobed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready <= '1;
      r_ls        <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_pid[i] <= 4'h0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_release && (r_grant == CH_W'(i))) begin
          r_req_ready[i] <= 1'b1;
        end else if (req_wen[i] && r_req_ready[i]) begin
          r_req_ready[i] <= 1'b0;
          r_pid[i]       <= req_pid[4*i +: 4];
          r_ls[i]        <= req_ls[i];
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign pkt_pid   = r_pkt_pid;
  assign pkt_wen   = r_pkt_wen;
  assign grant_ch  = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_usb_send_pkt_pre_arb.sv
// Directed bench for usb_send_pkt_pre_arb with default parameters (2 channels, PRE_GAP=4).
module tb_usb_send_pkt_pre_arb;

  logic       clk;
  logic       rst;
  logic [7:0] req_pid;
  logic [1:0] req_wen;
  logic [1:0] req_ls;
  logic [1:0] req_ready;
  logic [3:0] pkt_pid;
  logic       pkt_wen;
  logic       pkt_rdy;
  logic [0:0] grant_ch;
  logic       busy;

  int checks = 0;
  int errors = 0;

  usb_send_pkt_pre_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_pid   (req_pid),
    .req_wen   (req_wen),
    .req_ls    (req_ls),
    .req_ready (req_ready),
    .pkt_pid   (pkt_pid),
    .pkt_wen   (pkt_wen),
    .pkt_rdy   (pkt_rdy),
    .grant_ch  (grant_ch),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Runs n cycles after a request cycle t; s1/s2 are strobe cycles (0 = none),
  // r0/r1 are cycles where req_ready[ch] returns (0 = never dropped), b* are busy windows.
  task automatic watch(input int n, input int s1, input logic [3:0] p1,
                       input int s2, input logic [3:0] p2,
                       input int r0, input int r1,
                       input int b1f, input int b1t, input int b2f, input int b2t);
    for (int c = 1; c <= n; c++) begin
      tick();
      req_wen = 2'b00;
      chk("pkt_wen", c, 32'(pkt_wen), 32'(c == s1 || c == s2));
      if (c == s1) chk("pkt_pid_a", c, 32'(pkt_pid), 32'(p1));
      if (c == s2) chk("pkt_pid_b", c, 32'(pkt_pid), 32'(p2));
      chk("req_ready0", c, 32'(req_ready[0]), 32'(r0 == 0 || c >= r0));
      chk("req_ready1", c, 32'(req_ready[1]), 32'(r1 == 0 || c >= r1));
      chk("busy", c, 32'(busy), 32'((c >= b1f && c <= b1t) || (c >= b2f && c <= b2t)));
    end
  endtask

  initial begin
    rst = 1'b1; req_wen = 2'b00; req_ls = 2'b00; req_pid = 8'h00; pkt_rdy = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 0, 32'(req_ready), 32'h3);
    chk("rst_pkt_wen",   0, 32'(pkt_wen),   32'h0);
    chk("rst_pkt_pid",   0, 32'(pkt_pid),   32'h0);
    chk("rst_grant",     0, 32'(grant_ch),  32'h0);
    chk("rst_busy",      0, 32'(busy),      32'h0);
    rst = 1'b0;
    tick();
    tick();

    // Full-speed OUT on ch0
    req_pid = 8'h01; req_ls = 2'b00; req_wen = 2'b01;
    watch(7, 3, 4'h1, 0, 4'h0, 5, 0, 2, 5, 99, 0);
    chk("s1_grant", 7, 32'(grant_ch), 32'h0);

    // Low-speed PID 9 on ch1: PRE at t+3, PID at t+10
    req_pid = 8'h90; req_ls = 2'b10; req_wen = 2'b10;
    watch(14, 3, 4'hC, 10, 4'h9, 0, 12, 2, 12, 99, 0);
    chk("s2_grant", 14, 32'(grant_ch), 32'h1);

    // Simultaneous requests with rr_ptr=0, twice
    for (int k = 0; k < 2; k++) begin
      req_pid = 8'h32; req_ls = 2'b00; req_wen = 2'b11;
      watch(12, 3, 4'h2, 8, 4'h3, 5, 10, 2, 5, 7, 10);
      chk("s4_grant", 12, 32'(grant_ch), 32'h1);
    end

    // Low-speed SOF never gets a preamble
    req_pid = 8'h05; req_ls = 2'b01; req_wen = 2'b01;
    watch(7, 3, 4'h5, 0, 4'h0, 5, 0, 2, 5, 99, 0);
    chk("s3_grant", 7, 32'(grant_ch), 32'h0);

    // pkt_rdy low for 20 cycles in WAIT_PKT; second ch0 request must be dropped
    req_pid = 8'h03; req_ls = 2'b00; req_wen = 2'b01;
    for (int c = 1; c <= 30; c++) begin
      tick();
      req_wen = 2'b00;
      if (c == 1) pkt_rdy = 1'b0;
      if (c == 5) begin
        req_pid = 8'h0E; req_ls = 2'b01; req_wen = 2'b01;
      end
      if (c == 21) pkt_rdy = 1'b1;
      chk("s5_pkt_wen", c, 32'(pkt_wen), 32'(c == 22));
      if (c == 22) chk("s5_pkt_pid", c, 32'(pkt_pid), 32'h3);
      chk("s5_req_ready0", c, 32'(req_ready[0]), 32'(c >= 24));
      chk("s5_busy", c, 32'(busy), 32'(c >= 2 && c <= 24));
    end

    // Reset while in the post-PRE gap
    req_pid = 8'h90; req_ls = 2'b10; req_wen = 2'b10;
    for (int c = 1; c <= 7; c++) begin
      tick();
      req_wen = 2'b00;
      chk("s6_pkt_wen", c, 32'(pkt_wen), 32'(c == 3));
      if (c == 3) chk("s6_pre_pid", c, 32'(pkt_pid), 32'hC);
    end
    chk("s6_busy_pre", 7, 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_rst_pkt_wen",   8, 32'(pkt_wen),   32'h0);
    chk("s6_rst_req_ready", 8, 32'(req_ready), 32'h3);
    chk("s6_rst_busy",      8, 32'(busy),      32'h0);
    chk("s6_rst_grant",     8, 32'(grant_ch),  32'h0);
    chk("s6_rst_pkt_pid",   8, 32'(pkt_pid),   32'h0);
    // Request issued in the INIT cycle behaves like the first scenario
    req_pid = 8'h01; req_ls = 2'b00; req_wen = 2'b01;
    watch(7, 3, 4'h1, 0, 4'h0, 5, 0, 2, 5, 99, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
